// File: rtl/uart_baud_gen_if.sv
// rtl/uart_baud_gen_if.sv - control/strobe bundle between UART shift FSMs and the baud generator
//
// Purpose: groups the run request, rate select and timing strobes of
// uart_baud_gen so RX/TX shift FSMs connect through one port.
// Signals:
//   bps_start  : level request, high = run bit timing, low = abort/idle
//   rate_sel   : 0=9600 1=19200 2=38400 3=57600 4=115200, 5..7 invalid
//   clk_bps    : one-cycle mid-bit sample strobe
//   bit_end    : one-cycle bit-period-end strobe
//   bit_idx    : index of the current bit within the frame
//   frame_done : one-cycle pulse at the end of the last bit
//   busy       : high while bit timing is running
//   rate_err   : latched rate_sel was invalid
//   os_tick    : oversample tick (0 unless the oversample feature is built)
// Modports: master = shift FSM side, slave = baud generator side.

interface uart_baud_gen_if;
  logic       bps_start;
  logic [2:0] rate_sel;
  logic       clk_bps;
  logic       bit_end;
  logic [3:0] bit_idx;
  logic       frame_done;
  logic       busy;
  logic       rate_err;
  logic       os_tick;

  modport master (
    output bps_start, rate_sel,
    input  clk_bps, bit_end, bit_idx, frame_done, busy, rate_err, os_tick
  );

  modport slave (
    input  bps_start, rate_sel,
    output clk_bps, bit_end, bit_idx, frame_done, busy, rate_err, os_tick
  );
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - run-time selectable UART bit timing generator
//
// Purpose: divides the system clock to one of five baud rates (table derived
// from CLK_HZ), emits a mid-bit sample strobe and a bit-end strobe, and counts
// bits up to FRAME_BITS, pulsing frame_done on the last bit.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_baud_gen_if.slave (bps_start, rate_sel in; clk_bps, bit_end,
//           bit_idx, frame_done, busy, rate_err, os_tick out)
// Optional feature: define UART_BAUD_OSTICK_EN to build the os_tick counter;
// without it os_tick is tied to 0.

module uart_baud_gen #(
  parameter int CLK_HZ     = 50000000,
  parameter int CNT_W      = 16,
  parameter int FRAME_BITS = 10,
  parameter int OVERSAMPLE = 16
) (
  input logic            clk,
  input logic            rst_n,
  uart_baud_gen_if.slave bus
);

  if (FRAME_BITS < 2 || FRAME_BITS > 15) begin : g_bad_frame_bits
    $error("uart_baud_gen: FRAME_BITS must be 2..15");
  end
  if (OVERSAMPLE < 1) begin : g_bad_oversample
    $error("uart_baud_gen: OVERSAMPLE must be at least 1");
  end
  if (CNT_W < 32 && (CLK_HZ / 9600 - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("uart_baud_gen: CNT_W too narrow for the 9600 divisor");
  end

  localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(CLK_HZ / 9600 - 1);
  localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(CLK_HZ / 19200 - 1);
  localparam logic [CNT_W-1:0] DIV_38400  = CNT_W'(CLK_HZ / 38400 - 1);
  localparam logic [CNT_W-1:0] DIV_57600  = CNT_W'(CLK_HZ / 57600 - 1);
  localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(CLK_HZ / 115200 - 1);
  localparam logic [3:0]       LAST_IDX   = 4'(FRAME_BITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [3:0]       idx_q, idx_d;
  logic             bps_q, bps_d;
  logic             be_q, be_d;
  logic             fd_q, fd_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] sel_div;
  logic             sel_bad;
  logic             start_run;
  logic             abort;
  logic             running;
  logic             bit_wrap;

  // Invalid selections fall back to the slowest rate and flag rate_err.
  always_comb begin
    sel_div = DIV_9600;
    sel_bad = 1'b0;
    case (bus.rate_sel)
      3'd0:    sel_div = DIV_9600;
      3'd1:    sel_div = DIV_19200;
      3'd2:    sel_div = DIV_38400;
      3'd3:    sel_div = DIV_57600;
      3'd4:    sel_div = DIV_115200;
      default: sel_bad = 1'b1;
    endcase
  end

  assign start_run = (state_q == IDLE) && bus.bps_start;
  assign abort     = (state_q == RUN) && !bus.bps_start;
  assign running   = (state_q == RUN) && bus.bps_start;
  assign bit_wrap  = (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    half_d  = half_q;
    idx_d   = idx_q;
    bps_d   = 1'b0;
    be_d    = 1'b0;
    fd_d    = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    if (start_run) begin
      // Rate is only sampled here; changes during RUN wait for the next frame.
      div_d   = sel_div;
      half_d  = sel_div >> 1;
      err_d   = sel_bad;
      cnt_d   = '0;
      idx_d   = 4'd0;
      busy_d  = 1'b1;
      state_d = RUN;
    end else if (abort) begin
      // Abort wins over any count match on this edge: no strobes.
      cnt_d   = '0;
      idx_d   = 4'd0;
      busy_d  = 1'b0;
      state_d = IDLE;
    end else if (running) begin
      bps_d = (cnt_q == half_q);
      if (bit_wrap) begin
        cnt_d = '0;
        be_d  = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = 4'd0;
          fd_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_9600;
      half_q  <= DIV_9600 >> 1;
      idx_q   <= 4'd0;
      bps_q   <= 1'b0;
      be_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      half_q  <= half_d;
      idx_q   <= idx_d;
      bps_q   <= bps_d;
      be_q    <= be_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.clk_bps    = bps_q;
  assign bus.bit_end    = be_q;
  assign bus.bit_idx    = idx_q;
  assign bus.frame_done = fd_q;
  assign bus.busy       = busy_q;
  assign bus.rate_err   = err_q;

`ifdef UART_BAUD_OSTICK_EN
  logic [CNT_W:0]   os_period;
  logic [CNT_W-1:0] os_last_q, os_last_d;
  logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;

  // Tick spacing is fixed at latch time; the counter restarts at every bit
  // boundary so ticks stay aligned to the bit even when spacing does not
  // divide the bit period evenly.
  always_comb begin
    os_period = ({1'b0, sel_div} + (CNT_W+1)'(1)) / (CNT_W+1)'(OVERSAMPLE);
    os_last_d = os_last_q;
    os_cnt_d  = os_cnt_q;
    os_tick_d = 1'b0;
    if (start_run) begin
      os_last_d = (os_period == '0) ? '0 : CNT_W'(os_period - (CNT_W+1)'(1));
      os_cnt_d  = '0;
    end else if (abort) begin
      os_cnt_d = '0;
    end else if (running) begin
      os_tick_d = (os_cnt_q == os_last_q);
      os_cnt_d  = (bit_wrap || os_tick_d) ? '0 : os_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_last_q <= '0;
      os_cnt_q  <= '0;
      os_tick_q <= 1'b0;
    end else begin
      os_last_q <= os_last_d;
      os_cnt_q  <= os_cnt_d;
      os_tick_q <= os_tick_d;
    end
  end

  assign bus.os_tick = os_tick_q;
`else
  assign bus.os_tick = 1'b0;
`endif

endmodule
